// File: rtl/fifo_read_stream.sv
// Read-side adapter: FIFO read strobe + 2-entry skid buffer -> valid/ready stream.
// Optional beat counter output enabled by FIFO_READ_STREAM_BEAT_CNT_EN.
module fifo_read_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_read_en,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       occupancy
`ifdef FIFO_READ_STREAM_BEAT_CNT_EN
  ,
  output logic [15:0]      beat_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0][WIDTH-1:0]   mem_q, mem_d;
  logic                    head_q, head_d;
  logic                    tail_q, tail_d;
  logic                    inflight_q, inflight_d;
  logic                    pop;
  logic                    capture;
  logic [2:0]              credit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      mem_q      <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (capture) state_d = ONE;
      ONE: begin
        if (capture && !pop)      state_d = TWO;
        else if (!capture && pop) state_d = EMPTY;
      end
      TWO: if (pop && !capture) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    m_valid   = (state_q != EMPTY);
    m_data    = mem_q[head_q];
    occupancy = state_q;
    pop       = m_valid && m_ready;
    capture   = inflight_q;
    // Slots not yet claimed; a beat leaving this cycle frees one.
    credit    = 3'd2 - {1'b0, occupancy} - {2'b00, inflight_q}
              + {2'b00, pop};
    fifo_read_en = !fifo_empty && (credit != 3'd0) && !reset;
  end

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q ^ pop;
    tail_d     = tail_q ^ capture;
    inflight_d = fifo_read_en;
    if (capture) mem_d[tail_q] = fifo_read_data;
  end

`ifdef FIFO_READ_STREAM_BEAT_CNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb beat_cnt_d = beat_cnt_q + 16'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) beat_cnt_q <= '0;
    else       beat_cnt_q <= beat_cnt_d;
  end

  assign beat_count = beat_cnt_q;
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(state_q == TWO && capture && !pop));
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: behavioural FIFO upstream, scoreboard downstream.
// Counter checks run only when FIFO_READ_STREAM_BEAT_CNT_EN is defined.
module tb_fifo_read_stream;

  logic       clk;
  logic       reset;
  logic       fifo_empty;
  logic       fifo_read_en;
  logic [7:0] fifo_read_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [1:0] occupancy;
`ifdef FIFO_READ_STREAM_BEAT_CNT_EN
  logic [15:0] beat_count;
`endif

  fifo_read_stream #(.WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_read_en   (fifo_read_en),
    .fifo_read_data (fifo_read_data),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .occupancy      (occupancy)
`ifdef FIFO_READ_STREAM_BEAT_CNT_EN
    ,
    .beat_count     (beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       re;
    logic       mv;
    logic [7:0] d;
    logic [1:0] occ;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] fq [$];
  logic [7:0] expq [$];
  int         checks;
  int         errors;
  int         captured;
  int         popped;
  logic       last_rd;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fq.push_back(v);
    expq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Called at the negedge; advances to posedge+1.
  task automatic clk_edge();
    logic rd;
    logic pp;
    rd = fifo_read_en;
    pp = m_valid && m_ready;
    chk("rd_when_empty", {31'd0, rd && fq.size() == 0}, 32'd0);
    if (pp) begin
      if (expq.size() == 0) chk("sb_extra_beat", 32'd1, 32'd0);
      else chk("sb_data", {24'd0, m_data}, {24'd0, expq.pop_front()});
    end
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) fifo_read_data = fq.pop_front();
    captured += int'(last_rd);
    last_rd = rd;
    popped += int'(pp);
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic cycle();
    @(negedge clk);
    clk_edge();
  endtask

  task automatic clear_model();
    fq.delete();
    expq.delete();
    fifo_empty = 1'b1;
    captured = 0;
    popped = 0;
    last_rd = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] re_v;
    logic [11:0] mv_v;
    logic [7:0]  d2;
    logic [1:0]  oc3;
    int          n_wr;
    int          cyc;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    m_ready = 1'b0;
    fifo_read_data = 8'h00;
    clear_model();

    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h10, 2'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h10, 2'd2};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h10, 2'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h10, 2'd2};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 8'h11, 2'd1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 8'h12, 2'd1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 8'h13, 2'd1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

    #12;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_read_en", {31'd0, fifo_read_en}, 32'd0);
`ifdef FIFO_READ_STREAM_BEAT_CNT_EN
    chk("rst_beat_count", {16'd0, beat_count}, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single beat
    m_ready = 1'b1;
    push(8'hA5);
    re_v = '0;
    mv_v = '0;
    d2 = '0;
    oc3 = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      re_v[c] = fifo_read_en;
      mv_v[c] = m_valid;
      if (c == 2) d2 = m_data;
      if (c == 3) oc3 = occupancy;
      clk_edge();
    end
    chk("single_read_en", {20'd0, re_v}, 32'h001);
    chk("single_m_valid", {20'd0, mv_v}, 32'h004);
    chk("single_data", {24'd0, d2}, 32'hA5);
    chk("single_occ_after", {30'd0, oc3}, 32'd0);

    // Streaming
    for (int i = 0; i < 8; i++) push(8'(i));
    re_v = '0;
    mv_v = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      re_v[c] = fifo_read_en;
      mv_v[c] = m_valid;
      clk_edge();
    end
    chk("stream_read_en", {20'd0, re_v}, 32'h0FF);
    chk("stream_m_valid", {20'd0, mv_v}, 32'h3FC);
    chk("stream_drained", 32'(expq.size()), 32'd0);

    // Backpressure table
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    for (int r = 0; r < 10; r++) begin
      m_ready = tbl[r].rdy;
      @(negedge clk);
      chk($sformatf("bp_re_%0d", r), {31'd0, fifo_read_en}, {31'd0, tbl[r].re});
      chk($sformatf("bp_mv_%0d", r), {31'd0, m_valid}, {31'd0, tbl[r].mv});
      chk($sformatf("bp_occ_%0d", r), {30'd0, occupancy}, {30'd0, tbl[r].occ});
      if (tbl[r].mv)
        chk($sformatf("bp_data_%0d", r), {24'd0, m_data}, {24'd0, tbl[r].d});
      clk_edge();
    end
    chk("bp_drained", 32'(expq.size()), 32'd0);

    // Reset mid-stream with a full buffer
    m_ready = 1'b0;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    for (int c = 0; c < 4; c++) cycle();
    chk("pre_rst_occ", {30'd0, occupancy}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    chk("mid_rst_occ", {30'd0, occupancy}, 32'd0);
    chk("mid_rst_read_en", {31'd0, fifo_read_en}, 32'd0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, m_valid}, 32'd0);
      clk_edge();
    end

    // Random stall pattern against the scoreboard
    n_wr = 0;
    cyc = 0;
    while (!(n_wr == 64 && expq.size() == 0) && cyc < 3000) begin
      if (n_wr < 64 && $urandom_range(0, 2) == 0) begin
        push(8'($urandom));
        n_wr++;
      end
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rand_occ", {30'd0, occupancy}, 32'(captured - popped));
      chk("rand_occ_max", {31'd0, occupancy > 2'd2}, 32'd0);
      chk("rand_m_valid", {31'd0, m_valid}, {31'd0, captured != popped});
      clk_edge();
      cyc++;
    end
    chk("rand_timeout", {31'd0, cyc >= 3000}, 32'd0);
    chk("rand_drained", 32'(expq.size()), 32'd0);

`ifdef FIFO_READ_STREAM_BEAT_CNT_EN
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    for (int c = 0; c < 10; c++) cycle();
    chk("cnt_five", {16'd0, beat_count}, 32'd5);
    for (int i = 0; i < 65530; i++) push(8'(i));
    cyc = 0;
    while (expq.size() != 0 && cyc < 70000) begin
      cycle();
      cyc++;
    end
    for (int c = 0; c < 3; c++) cycle();
    chk("cnt_ffff", {16'd0, beat_count}, 32'hFFFF);
    push(8'h77);
    push(8'h78);
    for (int c = 0; c < 8; c++) cycle();
    chk("cnt_wrap", {16'd0, beat_count}, 32'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
